my_serial_alu_ctrl: RTL and testbench

Bit-serial sequencer that feeds the 1-bit `my_alui` slice. It accepts a WIDTH-bit operation request, drives operand bits LSB-first with the matching select lines into the slice over WIDTH cycles, and assembles the slice's `r` bits into a parallel result. It closes the slice's `cout` back to `cin` through its own carry flip-flop. The sequencer instantiates no ALU logic itself; the slice ports connect one-to-one to a `my_alui` instance.

---
 rtl/my_serial_alu_ctrl_if.sv | 30 +++
 rtl/my_serial_alu_ctrl.sv | 145 ++++++++++++++
 tb/tb_my_serial_alu_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/my_serial_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : my_serial_alu_ctrl_if
// Brief    : Request/response bundle of the bit-serial ALU sequencer.
// Revision : 1.0
// ============================================================================
interface my_serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, err, result, carry_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, err, result, carry_out
    );
endinterface
`default_nettype wire

// File: rtl/my_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : my_serial_alu_ctrl
// Brief    : Sequences WIDTH-bit operations LSB-first through a 1-bit ALU slice.
// Revision : 1.0
// ============================================================================
module my_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    my_serial_alu_ctrl_if.slave    bus,
    output logic                   alu_a,
    output logic                   alu_b,
    output logic                   alu_cin,
    output logic                   alu_s_sub,
    output logic                   alu_s_fas,
    output logic                   alu_s_and,
    output logic                   alu_s_or,
    output logic                   alu_s_xor,
    output logic                   alu_s_not,
    input  wire logic              alu_r,
    input  wire logic              alu_cout
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_err;

    logic             w_run;
    logic             w_legal;
    logic             w_arith;
    logic             w_last;

    assign w_run   = (r_state == S_RUN);
    assign w_legal = (bus.op <= OP_NOT);
    assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_op        <= OP_ADD;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (bus.start) begin
                        if (w_legal) begin
                            r_a_sh  <= bus.a_in;
                            r_b_sh  <= bus.b_in;
                            r_op    <= bus.op;
                            r_cnt   <= '0;
                            // SUB is a + ~b + 1: the +1 enters as the initial carry
                            r_carry <= (bus.op == OP_SUB);
                            r_state <= S_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_res_sh <= {alu_r, r_res_sh[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_arith) begin
                        r_carry <= alu_cout;
                    end
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_result    <= {alu_r, r_res_sh[WIDTH-1:1]};
                        r_carry_out <= w_arith ? alu_cout : 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_cin   = 1'b0;
        alu_s_sub = 1'b0;
        alu_s_fas = 1'b0;
        alu_s_and = 1'b0;
        alu_s_or  = 1'b0;
        alu_s_xor = 1'b0;
        alu_s_not = 1'b0;
        if (w_run) begin
            alu_a   = r_a_sh[0];
            alu_b   = r_b_sh[0];
            alu_cin = r_carry;
            case (r_op)
                OP_ADD: alu_s_fas = 1'b1;
                OP_SUB: begin
                    alu_s_fas = 1'b1;
                    alu_s_sub = 1'b1;
                end
                OP_AND: alu_s_and = 1'b1;
                OP_OR:  alu_s_or  = 1'b1;
                OP_XOR: alu_s_xor = 1'b1;
                OP_NOT: alu_s_not = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_run;
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = r_err;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_my_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_serial_alu_ctrl
// Brief    : Directed scoreboard bench; a behavioural 1-bit slice closes the loop.
// Revision : 1.0
// ============================================================================
module tb_my_serial_alu_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] res;
        logic       cy;
        logic [5:0] sel;
        logic       cin;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    my_serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus();

    logic alu_a, alu_b, alu_cin;
    logic alu_s_sub, alu_s_fas, alu_s_and, alu_s_or, alu_s_xor, alu_s_not;
    logic alu_r, alu_cout;
    logic bb;

    my_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_s_sub (alu_s_sub),
        .alu_s_fas (alu_s_fas),
        .alu_s_and (alu_s_and),
        .alu_s_or  (alu_s_or),
        .alu_s_xor (alu_s_xor),
        .alu_s_not (alu_s_not),
        .alu_r     (alu_r),
        .alu_cout  (alu_cout)
    );

    // Slice: full adder with optional b inversion, plus bitwise functions
    always_comb begin
        bb       = alu_b ^ alu_s_sub;
        alu_r    = 1'b0;
        alu_cout = 1'b0;
        if (alu_s_fas) begin
            alu_r    = alu_a ^ bb ^ alu_cin;
            alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
        end else if (alu_s_and) alu_r = alu_a & alu_b;
        else if (alu_s_or)      alu_r = alu_a | alu_b;
        else if (alu_s_xor)     alu_r = alu_a ^ alu_b;
        else if (alu_s_not)     alu_r = ~alu_a;
    end

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    function automatic logic [5:0] sel_vec();
        return {alu_s_sub, alu_s_fas, alu_s_and, alu_s_or, alu_s_xor, alu_s_not};
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [8:0] s;
        e.res = 8'h00; e.cy = 1'b0; e.sel = 6'b000000; e.cin = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b};         e.res = s[7:0]; e.cy = s[8]; e.sel = 6'b010000; end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; e.res = s[7:0]; e.cy = s[8]; e.sel = 6'b110000; e.cin = 1'b1; end
            3'd2: begin e.res = a & b; e.sel = 6'b001000; end
            3'd3: begin e.res = a | b; e.sel = 6'b000100; end
            3'd4: begin e.res = a ^ b; e.sel = 6'b000010; end
            3'd5: begin e.res = ~a;    e.sel = 6'b000001; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        sb.push_back(model(op, a, b));
    endtask

    // Starts from a cycle where start is already driven; returns in the done cycle
    task automatic finish(input string tag, input bit glitch);
        exp_t e;
        int   n;
        logic sel_ok;
        e = sb[0];
        step();
        bus.start = 1'b0;
        n = 1;
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        check({tag, " cin0"}, 32'(alu_cin), 32'(e.cin));
        sel_ok = 1'b1;
        while (!bus.done && n < 20) begin
            if (bus.busy && sel_vec() != e.sel) sel_ok = 1'b0;
            if (glitch && n == 3) begin
                bus.start = 1'b1; bus.op = 3'd4; bus.a_in = 8'hFF; bus.b_in = 8'h81;
            end else if (glitch && n == 4) begin
                bus.start = 1'b0;
            end
            step();
            n++;
        end
        check({tag, " sel"}, 32'(sel_ok), 32'd1);
        check({tag, " latency"}, 32'(n), 32'd9);
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " err"}, 32'(bus.err), 32'd0);
        e = sb.pop_front();
        check({tag, " result"}, 32'(bus.result), 32'(e.res));
        check({tag, " carry"}, 32'(bus.carry_out), 32'(e.cy));
    endtask

    initial begin
        exp_t dropped;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a_in  = 8'h00;
        bus.b_in  = 8'h00;
        #12;
        check("rst busy/done/err", 32'({bus.busy, bus.done, bus.err}), 32'd0);
        check("rst result/carry", 32'({bus.result, bus.carry_out}), 32'd0);
        check("rst alu outputs", 32'({alu_a, alu_b, alu_cin, sel_vec()}), 32'd0);
        rst_n = 1'b1;
        step();

        launch(3'd0, 8'h5A, 8'h3C); finish("add 5a+3c", 1'b0);
        step();
        check("done single pulse", 32'(bus.done), 32'd0);
        check("idle busy", 32'(bus.busy), 32'd0);

        launch(3'd0, 8'hFF, 8'h01); finish("add ff+01", 1'b0); step();
        launch(3'd1, 8'h10, 8'h01); finish("sub 10-01", 1'b0); step();
        launch(3'd1, 8'h01, 8'h02); finish("sub 01-02", 1'b0); step();
        for (int op = 2; op <= 5; op++) begin
            launch(3'(op), 8'hF0, 8'h3C);
            finish($sformatf("logic op%0d", op), 1'b0);
            step();
        end

        launch(3'd0, 8'h5A, 8'h3C); finish("start mid-run", 1'b1); step();

        launch(3'd1, 8'h10, 8'h01); finish("chain first", 1'b0);
        launch(3'd3, 8'h12, 8'h40); finish("chain second", 1'b0);
        step();

        bus.start = 1'b1; bus.op = 3'd6; bus.a_in = 8'hAA; bus.b_in = 8'h55;
        step();
        bus.start = 1'b0;
        check("illegal err", 32'(bus.err), 32'd1);
        check("illegal busy", 32'(bus.busy), 32'd0);
        check("illegal done", 32'(bus.done), 32'd0);
        step();
        check("illegal err pulse", 32'(bus.err), 32'd0);
        check("illegal result kept", 32'(bus.result), 32'h52);

        launch(3'd0, 8'h33, 8'h44);
        step();
        bus.start = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        dropped = sb.pop_front();
        check("reset busy/done/err", 32'({bus.busy, bus.done, bus.err}), 32'd0);
        check("reset result/carry", 32'({bus.result, bus.carry_out}), 32'd0);
        check("reset alu outputs", 32'({alu_a, alu_b, alu_cin, sel_vec()}), 32'd0);
        step(); step();
        check("reset no done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        step();
        launch(3'd0, 8'h01, 8'h01); finish("add after reset", 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
